// File: rtl/vga_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vga_frame_sequencer
// Description : VGA pixel enable, h/v counters, registered sync/blank strobes
//               and a frame-boundary-committed pattern-mode register.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_frame_sequencer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int MODE_W     = 3,
    parameter int SYNC_STG   = 2,
    parameter int RESET_MODE = 0
) (
    input  logic              CLOCK_50,
    input  logic              KEY,
    input  logic [MODE_W-1:0] mode_req,
    output logic              pix_en,
    output logic [9:0]        h_count,
    output logic [9:0]        v_count,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              blank_n,
    output logic              frame_start,
    output logic [MODE_W-1:0] mode_active,
    output logic              mode_pending
);

    localparam logic [9:0] c_h_last     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_v_last     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_h_active   = 10'(H_ACTIVE);
    localparam logic [9:0] c_v_active   = 10'(V_ACTIVE);
    localparam logic [9:0] c_hs_first   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] c_hs_last    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_vs_first   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_vs_last    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [MODE_W-1:0] c_reset_mode = MODE_W'(RESET_MODE);

    logic                             pix_en_q, pix_en_d;
    logic [9:0]                       h_q, h_d;
    logic [9:0]                       v_q, v_d;
    logic                             hsync_n_q, hsync_n_d;
    logic                             vsync_n_q, vsync_n_d;
    logic                             blank_n_q, blank_n_d;
    logic                             frame_start_q, frame_start_d;
    logic [MODE_W-1:0]                mode_active_q, mode_active_d;
    logic                             mode_pending_q, mode_pending_d;
    logic [SYNC_STG-1:0][MODE_W-1:0]  sync_q, sync_d;
    logic                             advance;
    logic [MODE_W-1:0]                req_s, req_s_d;

    always_comb begin
        advance  = pix_en_q;
        pix_en_d = ~pix_en_q;
        h_d      = h_q;
        v_d      = v_q;
        if (advance) begin
            if (h_q == c_h_last) begin
                h_d = '0;
                v_d = (v_q == c_v_last) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Strobes decode the next-state counters so they line up with h/v.
        hsync_n_d     = !((h_d >= c_hs_first) && (h_d <= c_hs_last));
        vsync_n_d     = !((v_d >= c_vs_first) && (v_d <= c_vs_last));
        blank_n_d     = (h_d < c_h_active) && (v_d < c_v_active);
        frame_start_d = advance && (h_d == '0) && (v_d == '0);

        sync_d  = {sync_q[SYNC_STG-2:0], mode_req};
        req_s   = sync_q[SYNC_STG-1];
        req_s_d = sync_d[SYNC_STG-1];

        // Commit uses the pre-edge synchronised request.
        mode_active_d  = frame_start_d ? req_s : mode_active_q;
        mode_pending_d = (req_s_d != mode_active_d);
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            pix_en_q       <= 1'b0;
            h_q            <= c_h_last;
            v_q            <= c_v_last;
            hsync_n_q      <= 1'b1;
            vsync_n_q      <= 1'b1;
            blank_n_q      <= 1'b0;
            frame_start_q  <= 1'b0;
            mode_active_q  <= c_reset_mode;
            mode_pending_q <= 1'b0;
            sync_q         <= {SYNC_STG{c_reset_mode}};
        end else begin
            pix_en_q       <= pix_en_d;
            h_q            <= h_d;
            v_q            <= v_d;
            hsync_n_q      <= hsync_n_d;
            vsync_n_q      <= vsync_n_d;
            blank_n_q      <= blank_n_d;
            frame_start_q  <= frame_start_d;
            mode_active_q  <= mode_active_d;
            mode_pending_q <= mode_pending_d;
            sync_q         <= sync_d;
        end
    end

    assign pix_en       = pix_en_q;
    assign h_count      = h_q;
    assign v_count      = v_q;
    assign hsync_n      = hsync_n_q;
    assign vsync_n      = vsync_n_q;
    assign blank_n      = blank_n_q;
    assign frame_start  = frame_start_q;
    assign mode_active  = mode_active_q;
    assign mode_pending = mode_pending_q;

endmodule
`default_nettype wire
